l1_dm_cache: RTL



---
 rtl/l1_dm_cache_pkg.sv | 25 ++
 rtl/l1_dm_cache_array.sv | 79 +++++++
 rtl/l1_dm_cache.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/l1_dm_cache_pkg.sv
// Shared types for the direct-mapped L1 cache: line/tag types, FSM encoding
// and the byte-lane write-mask helper.
package cache_types;

  localparam int OFFSET_BITS = 5;
  localparam int LINE_BYTES  = 32;
  localparam int DEF_S_INDEX = 3;
  localparam int TAG_BITS    = 32 - OFFSET_BITS - DEF_S_INDEX;

  typedef logic [255:0]        line_t;
  typedef logic [TAG_BITS-1:0] tag_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_state_t;

  // Spread a 4-bit word byte-enable onto its lanes within the 32-byte line.
  function automatic logic [LINE_BYTES-1:0] lane_mask(input logic [2:0] word_sel,
                                                      input logic [3:0] be);
    lane_mask = {28'd0, be} << {word_sel, 2'b00};
  endfunction

endpackage

// File: rtl/l1_dm_cache_array.sv
// Set storage for l1_dm_cache: async-reset valid/dirty bits, unreset tag and
// line arrays, combinational read, per-byte write and full-line load.
module cache_array
  import cache_types::*;
#(
  parameter int S_INDEX = 3,
  parameter int TAG_W   = 32 - OFFSET_BITS - S_INDEX
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [S_INDEX-1:0]    rd_index,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output line_t                 rd_line,
  input  logic [S_INDEX-1:0]    wr_index,
  input  logic [LINE_BYTES-1:0] byte_we,
  input  line_t                 wr_line,
  input  logic                  set_dirty,
  input  logic                  clr_dirty,
  input  logic                  load_en,
  input  logic [TAG_W-1:0]      load_tag,
  input  line_t                 load_line
);

  localparam int SETS = 1 << S_INDEX;

  logic [SETS-1:0]  valid_q, valid_d;
  logic [SETS-1:0]  dirty_q, dirty_d;
  logic [TAG_W-1:0] tag_mem  [SETS];
  line_t            data_mem [SETS];

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_line  = data_mem[rd_index];

  // Status-bit update: a line load wins over dirty set/clear.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (load_en) begin
      valid_d[wr_index] = 1'b1;
      dirty_d[wr_index] = 1'b0;
    end else if (set_dirty) begin
      dirty_d[wr_index] = 1'b1;
    end else if (clr_dirty) begin
      dirty_d[wr_index] = 1'b0;
    end else begin
      dirty_d = dirty_q;
    end
  end

  // Status-bit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and line storage.
  always_ff @(posedge clk) begin
    if (load_en) begin
      tag_mem[wr_index]  <= load_tag;
      data_mem[wr_index] <= load_line;
    end else begin
      for (int i = 0; i < LINE_BYTES; i++) begin
        if (byte_we[i]) begin
          data_mem[wr_index][i*8 +: 8] <= wr_line[i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/l1_dm_cache.sv
// Direct-mapped write-back/write-allocate L1 cache. Optional hit/miss counters
// are enabled by defining L1_DM_CACHE_PERF_EN.
module l1_dm_cache
  import cache_types::*;
#(
  parameter int S_INDEX = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
`ifdef L1_DM_CACHE_PERF_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int TAG_W = 32 - OFFSET_BITS - S_INDEX;

  cache_state_t state_q, state_d;
  logic [S_INDEX-1:0] miss_index_q, miss_index_d;
  logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;

  logic [S_INDEX-1:0]    req_index_s, arr_rd_index_s, arr_wr_index_s;
  logic [TAG_W-1:0]      req_tag_s, arr_tag_s, arr_load_tag_s;
  logic [2:0]            req_word_s;
  logic                  req_s, hit_s, arr_valid_s, arr_dirty_s;
  logic                  arr_set_dirty_s, arr_clr_dirty_s, arr_load_s;
  logic [LINE_BYTES-1:0] arr_byte_we_s;
  line_t                 arr_line_s, arr_load_line_s;
  logic                  addr_unused_s;

  assign req_index_s    = mem_address[OFFSET_BITS +: S_INDEX];
  assign req_tag_s      = mem_address[31 -: TAG_W];
  assign req_word_s     = mem_address[4:2];
  assign req_s          = mem_read | mem_write;
  assign addr_unused_s  = &{1'b0, mem_address[1:0]};
  // Outside IDLE the array is addressed by the latched miss, not the live bus.
  assign arr_rd_index_s = (state_q == IDLE) ? req_index_s : miss_index_q;
  assign hit_s          = arr_valid_s && (arr_tag_s == req_tag_s);

  cache_array #(
    .S_INDEX (S_INDEX),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_index  (arr_rd_index_s),
    .rd_valid  (arr_valid_s),
    .rd_dirty  (arr_dirty_s),
    .rd_tag    (arr_tag_s),
    .rd_line   (arr_line_s),
    .wr_index  (arr_wr_index_s),
    .byte_we   (arr_byte_we_s),
    .wr_line   ({8{mem_wdata}}),
    .set_dirty (arr_set_dirty_s),
    .clr_dirty (arr_clr_dirty_s),
    .load_en   (arr_load_s),
    .load_tag  (arr_load_tag_s),
    .load_line (arr_load_line_s)
  );

  // State and miss-latch register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      miss_index_q <= '0;
      miss_tag_q   <= '0;
    end else begin
      state_q      <= state_d;
      miss_index_q <= miss_index_d;
      miss_tag_q   <= miss_tag_d;
    end
  end

  // Next-state logic; a miss captures index/tag so the fill ignores bus changes.
  always_comb begin
    state_d      = state_q;
    miss_index_d = miss_index_q;
    miss_tag_d   = miss_tag_q;
    case (state_q)
      IDLE: begin
        if (req_s && !hit_s) begin
          miss_index_d = req_index_s;
          miss_tag_d   = req_tag_s;
          state_d      = (arr_valid_s && arr_dirty_s) ? WRITEBACK : ALLOCATE;
        end else begin
          state_d = IDLE;
        end
      end
      WRITEBACK: state_d = pmem_resp ? ALLOCATE : WRITEBACK;
      ALLOCATE:  state_d = pmem_resp ? IDLE : ALLOCATE;
      default:   state_d = IDLE;
    endcase
  end

  // Output and array-control logic.
  always_comb begin
    mem_rdata       = 32'd0;
    mem_resp        = 1'b0;
    pmem_address    = 32'd0;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    pmem_wdata      = '0;
    arr_wr_index_s  = req_index_s;
    arr_byte_we_s   = '0;
    arr_set_dirty_s = 1'b0;
    arr_clr_dirty_s = 1'b0;
    arr_load_s      = 1'b0;
    arr_load_tag_s  = miss_tag_q;
    arr_load_line_s = pmem_rdata;
    case (state_q)
      IDLE: begin
        if (req_s && hit_s) begin
          mem_resp  = 1'b1;
          mem_rdata = arr_line_s[{req_word_s, 5'b00000} +: 32];
          if (mem_write) begin
            arr_byte_we_s   = lane_mask(req_word_s, mem_byte_enable);
            arr_set_dirty_s = |mem_byte_enable;
          end else begin
            arr_byte_we_s = '0;
          end
        end else begin
          mem_resp = 1'b0;
        end
      end
      WRITEBACK: begin
        pmem_write      = 1'b1;
        pmem_address    = {arr_tag_s, miss_index_q, 5'b00000};
        pmem_wdata      = arr_line_s;
        arr_wr_index_s  = miss_index_q;
        arr_clr_dirty_s = pmem_resp;
      end
      ALLOCATE: begin
        pmem_read      = 1'b1;
        pmem_address   = {miss_tag_q, miss_index_q, 5'b00000};
        arr_wr_index_s = miss_index_q;
        arr_load_s     = pmem_resp;
      end
      default: begin
        mem_resp = 1'b0;
      end
    endcase
  end

`ifdef L1_DM_CACHE_PERF_EN
  logic        missed_q, missed_d;
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  // Saturating counters; a hit that completes a miss is not counted as a hit.
  always_comb begin
    missed_d     = missed_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == IDLE && req_s && !hit_s) begin
      missed_d = 1'b1;
      if (miss_count_q != 32'hFFFF_FFFF) begin
        miss_count_d = miss_count_q + 32'd1;
      end else begin
        miss_count_d = miss_count_q;
      end
    end else if (mem_resp) begin
      missed_d = 1'b0;
      if (!missed_q && hit_count_q != 32'hFFFF_FFFF) begin
        hit_count_d = hit_count_q + 32'd1;
      end else begin
        hit_count_d = hit_count_q;
      end
    end else begin
      missed_d = missed_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      missed_q     <= 1'b0;
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      missed_q     <= missed_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end
`endif

endmodule
